ami_w_split: RTL
================

// Module: ami_w_split
// PURPOSE
//  Single-clock AXI master write interface that accepts long user write commands and
//  splits them into legal AXI INCR bursts. Each burst is capped at MAX_BEATS and never
//  crosses a 4KB boundary. WLAST is generated internally from the burst-length queue.
//  The B responses of one command's sub-bursts are merged into a single user response.
//  Sits between a DMA/user engine and the AXI interconnect, in the ACLK domain only.
// PARAMETERS
//  AXI_DW     128  data bus width, power of 2, >=16
//  AXI_AW     40   address width
//  AXI_IW     8    ID width
//  USR_LW     16   user length width (usr_awlen = beats-1)
//  MAX_BEATS  16   max beats per AXI burst, power of 2, 1..256
//  AMI_OD     4    max outstanding AXI bursts (AW accepted, B not yet received)
//  AMI_WD     64   W data FIFO depth, power of 2
//  AXI_BYTES  AXI_DW/8   derived; ABW = $clog2(AXI_BYTES)
// PORTS
//  ACLK         in   1             clock
//  ARESETn      in   1             async active-low reset
//  AWID         out  AXI_IW        = latched usr_awid, same for every sub-burst
//  AWADDR       out  AXI_AW        sub-burst start address, low ABW bits zero
//  AWLEN        out  8             sub-burst beats-1
//  AWSIZE       out  3             constant ABW
//  AWBURST      out  2             constant 2'b01 (INCR)
//  AWVALID/AWREADY  out/in  1      AW handshake
//  WDATA/WSTRB  out  AXI_DW/AXI_BYTES  head of W FIFO
//  WLAST        out  1             last beat of current sub-burst
//  WVALID/WREADY    out/in  1      W handshake
//  BID/BRESP    in   AXI_IW/2      write response
//  BVALID/BREADY    in/out  1      B handshake
//  usr_awid/usr_awaddr/usr_awlen  in  AXI_IW/AXI_AW/USR_LW  command fields
//  usr_awvalid/usr_awready        in/out  1                 command handshake
//  usr_wdata/usr_wstrb            in  AXI_DW/AXI_BYTES      write data
//  usr_wvalid/usr_wready          in/out  1                 data handshake
//  usr_bid/usr_bresp              out AXI_IW/2              merged response
//  usr_bvalid/usr_bready          out/in  1                 response handshake
// BEHAVIOUR
//  Reset: AWVALID, WVALID, WLAST, usr_bvalid = 0. All FIFOs and counters are cleared.
//    BREADY=0. usr_awready=1 and usr_wready=1 from the first cycle after reset release.
//  Splitter FSM IDLE/ISSUE:
//  - IDLE: usr_awready=1. On handshake, latch id and addr with low ABW bits forced to 0.
//    Latch rem=usr_awlen+1 (USR_LW+1 bits). Go to ISSUE.
//  - ISSUE: sub = min(rem, MAX_BEATS, (4096-addr[11:0])>>ABW). AWLEN = sub-1.
//  - ISSUE: AWVALID = ost<AMI_OD && lenq not full && bq not full.
//  - AW fields are stable while AWVALID && !AWREADY.
//  - On AW handshake: addr+=sub<<ABW, rem-=sub. Push sub-1 to lenq.
//    Push last=(rem==sub) to bq. If rem==sub, go to IDLE, else the next sub-burst is
//    presented in the following cycle.
//  - AWVALID first rises 1 cycle after the usr_aw handshake.
//  W path: usr_wready = !wfifo_full. usr_wlast does not exist; usr supplies exactly
//    len+1 beats per command, in command order.
//  - WVALID = !wfifo_empty && !lenq_empty, so a beat never precedes its AW handshake.
//  - beat counter bc counts W handshakes. WLAST = WVALID && bc==lenq_head.
//  - On a WLAST handshake: pop lenq, bc=0.
//  - Data latency: usr beat to WVALID is 1 cycle minimum.
//  Outstanding count ost, width $clog2(AMI_OD+1): +1 on AW handshake, -1 on B handshake.
//    Simultaneous +1/-1 leaves it unchanged. ost never exceeds AMI_OD.
//  B merge: acc holds the numeric max of BRESP over the current command's sub-bursts.
//  - BREADY = !bq_empty && (!bq_head.last || !usr_bvalid || usr_bready).
//  - On a B handshake: pop bq. If last: usr_bid=BID, usr_bresp=max(acc,BRESP),
//    usr_bvalid=1, acc=0. Otherwise acc=max(acc,BRESP).
//  - usr_bvalid stays held until usr_bready. Back-to-back responses lose no cycle.
//  A BID mismatch with the issued ID is ignored. AXI same-ID ordering is relied on.
//  Reset mid-operation drops all queued commands, data and pending responses.
// TESTING
//  T1 addr=0x1000 len=3, AXI_DW=128 -> one AW (0x1000,AWLEN=3), 4 W beats with WLAST on
//     beat 4, one usr_b OKAY.
//  T2 addr=0 len=39 -> AWs (0x000,15),(0x100,15),(0x200,7), WLAST on beats 16/32/40,
//     exactly one usr_b.
//  T3 addr=0xFC5 len=7 -> address aligned to 0xFC0. AWs (0xFC0,3),(0x1000,3); no burst
//     crosses 4KB.
//  T4 len=95 (6 bursts), AWREADY=1, BVALID=0 -> exactly 4 AW handshakes, then AWVALID=0
//     until the first B, then 1 more AW.
//  T5 3 sub-bursts with BRESP OKAY,SLVERR,OKAY and usr_bready=0 for 5 cycles ->
//     usr_bresp=2'b10 held. The next command's final B gets BREADY=0 until taken.
//  T6 ARESETn low while a burst is mid-way -> all outputs take reset values. A fresh T1
//     then passes.

Source files
------------

// File: rtl/ami_w_split.sv
// ami_w_split: splits long user write commands into 4KB-safe AXI INCR bursts and merges their responses
module ami_w_split_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = D > 1 ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  logic [W-1:0] mem [D];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  assign full = cnt == CW'(D);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  // circular pointers and occupancy; callers never push when full or pop when empty
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp == PW'(D - 1) ? '0 : wp + PW'(1);
      if (pop) rp <= rp == PW'(D - 1) ? '0 : rp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  // storage holds only data, so it needs no reset
  always_ff @(posedge ACLK)
    if (push) mem[wp] <= din;
endmodule

module ami_w_split #(
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 40,
  parameter int AXI_IW = 8,
  parameter int USR_LW = 16,
  parameter int MAX_BEATS = 16,
  parameter int AMI_OD = 4,
  parameter int AMI_WD = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  output logic [AXI_IW-1:0]     AWID,
  output logic [AXI_AW-1:0]     AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [AXI_DW-1:0]     WDATA,
  output logic [AXI_DW/8-1:0]   WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [AXI_IW-1:0]     BID,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [AXI_IW-1:0]     usr_awid,
  input  logic [AXI_AW-1:0]     usr_awaddr,
  input  logic [USR_LW-1:0]     usr_awlen,
  input  logic                  usr_awvalid,
  output logic                  usr_awready,
  input  logic [AXI_DW-1:0]     usr_wdata,
  input  logic [AXI_DW/8-1:0]   usr_wstrb,
  input  logic                  usr_wvalid,
  output logic                  usr_wready,
  output logic [AXI_IW-1:0]     usr_bid,
  output logic [1:0]            usr_bresp,
  output logic                  usr_bvalid,
  input  logic                  usr_bready
);
  localparam int AXI_BYTES = AXI_DW / 8;
  localparam int ABW = $clog2(AXI_BYTES);
  localparam int RW = USR_LW + 1;
  localparam int SW = RW > 13 ? RW : 13;
  localparam int OW = $clog2(AMI_OD + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;
  logic [0:0] state;
  logic [AXI_IW-1:0] id_q;
  logic [AXI_AW-1:0] addr_q;
  logic [RW-1:0] rem_q;
  logic [OW-1:0] ost;
  logic [7:0] bc, lq_head;
  logic [1:0] acc, bmax;
  logic [SW-1:0] room, cap, sub;
  logic cmd_hs, aw_hs, w_hs, b_hs, aw_last;
  logic lq_full, lq_empty, bq_full, bq_empty, bq_last, wf_full, wf_empty;
  logic [AXI_DW+AXI_BYTES-1:0] wf_dout;
  assign room = SW'((13'd4096 - {1'b0, addr_q[11:0]}) >> ABW);
  assign cap = SW'(rem_q) < SW'(MAX_BEATS) ? SW'(rem_q) : SW'(MAX_BEATS);
  assign sub = room < cap ? room : cap;
  assign aw_last = SW'(rem_q) == sub;
  assign AWID = id_q;
  assign AWADDR = addr_q;
  assign AWLEN = 8'(sub - SW'(1));
  assign AWSIZE = 3'(ABW);
  assign AWBURST = 2'b01;
  assign AWVALID = state == S_ISSUE && ost < OW'(AMI_OD) && !lq_full && !bq_full;
  assign usr_awready = state == S_IDLE;
  assign usr_wready = !wf_full;
  assign {WDATA, WSTRB} = wf_dout;
  assign WVALID = !wf_empty && !lq_empty;
  assign WLAST = WVALID && bc == lq_head;
  assign BREADY = !bq_empty && (!bq_last || !usr_bvalid || usr_bready);
  assign cmd_hs = usr_awvalid && usr_awready;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs = WVALID && WREADY;
  assign b_hs = BVALID && BREADY;
  assign bmax = BRESP > acc ? BRESP : acc;
  ami_w_split_fifo #(.W(8), .D(AMI_OD)) u_lenq (
    .ACLK(ACLK), .ARESETn(ARESETn), .push(aw_hs), .din(AWLEN), .pop(w_hs && WLAST),
    .dout(lq_head), .full(lq_full), .empty(lq_empty)
  );
  ami_w_split_fifo #(.W(1), .D(AMI_OD)) u_bq (
    .ACLK(ACLK), .ARESETn(ARESETn), .push(aw_hs), .din(aw_last), .pop(b_hs),
    .dout(bq_last), .full(bq_full), .empty(bq_empty)
  );
  ami_w_split_fifo #(.W(AXI_DW + AXI_BYTES), .D(AMI_WD)) u_wf (
    .ACLK(ACLK), .ARESETn(ARESETn), .push(usr_wvalid && usr_wready), .din({usr_wdata, usr_wstrb}),
    .pop(w_hs), .dout(wf_dout), .full(wf_full), .empty(wf_empty)
  );
  // latch a command, then walk it one sub-burst per AW handshake
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      state <= S_IDLE;
      id_q <= '0;
      addr_q <= '0;
      rem_q <= '0;
    end else if (cmd_hs) begin
      state <= S_ISSUE;
      id_q <= usr_awid;
      addr_q <= usr_awaddr & ~AXI_AW'(AXI_BYTES - 1);
      rem_q <= RW'(usr_awlen) + RW'(1);
    end else if (aw_hs) begin
      state <= aw_last ? S_IDLE : S_ISSUE;
      addr_q <= addr_q + (AXI_AW'(sub) << ABW);
      rem_q <= rem_q - RW'(sub);
    end
  // bursts accepted on AW but not yet answered on B
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) ost <= '0;
    else ost <= ost + OW'(aw_hs) - OW'(b_hs);
  // beat position inside the burst at the head of the length queue
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) bc <= '0;
    else if (w_hs) bc <= WLAST ? '0 : bc + 8'd1;
  // worst response of a command's sub-bursts, reported once on its final B
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      usr_bvalid <= 1'b0;
      usr_bid <= '0;
      usr_bresp <= '0;
      acc <= '0;
    end else if (b_hs && bq_last) begin
      usr_bvalid <= 1'b1;
      usr_bid <= BID;
      usr_bresp <= bmax;
      acc <= '0;
    end else begin
      if (usr_bready) usr_bvalid <= 1'b0;
      if (b_hs) acc <= bmax;
    end
endmodule
